// File: rtl/mux_scan_serializer.sv
// -----------------------------------------------------------------------------
// mux_scan_serializer
//
// Serializes an 8-bit word by steering an external 8:1 mux. The held word
// (mux_in_o) and the bit index (sel_o) go out to the mux. The selected bit
// comes back on mux_out_i and is passed straight through to sout_o.
//
// Handshakes (valid/ready on both sides):
//   A transfer happens on a rising edge where valid & ready are both 1.
//   Valid never depends on ready. A source holds its valid and data until
//   the transfer happens. On the serial side, sout_valid_o stays high and
//   sel_o stays put until the sink accepts the bit.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_n_i        asynchronous, active-low reset
//   din_i[7:0]     parallel word to serialize
//   load_valid_i   din_i is valid
//   load_ready_o   block accepts din_i this cycle
//   mux_in_o[7:0]  held word, drives the data inputs of the external mux
//   sel_o[2:0]     bit index, drives the select of the external mux
//   mux_out_i      bit selected by the external mux
//   sout_o         serial data bit (equal to mux_out_i)
//   sout_valid_o   sout_o holds a valid bit
//   sout_ready_i   sink accepts sout_o this cycle
//   sout_last_o    current bit is the 8th bit of its word
//   word_cnt_o     count of fully sent words, modulo 256
//   state_o        debug view of the FSM: 0 = IDLE, 1 = SHIFT
// -----------------------------------------------------------------------------
module mux_scan_serializer #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] din_i,
    input  logic       load_valid_i,
    output logic       load_ready_o,
    output logic [7:0] mux_in_o,
    output logic [2:0] sel_o,
    input  logic       mux_out_i,
    output logic       sout_o,
    output logic       sout_valid_o,
    input  logic       sout_ready_i,
    output logic       sout_last_o,
    output logic [7:0] word_cnt_o,
    output logic       state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] SEL_FIRST = LSB_FIRST ? 3'd0 : 3'd7;

    state_t     state_q, state_d;
    logic [7:0] mux_in_q, mux_in_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] word_cnt_q, word_cnt_d;

    logic shifting;
    logic last;
    logic xfer;
    logic load;

    assign shifting = (state_q == SHIFT);
    assign last     = shifting && (bcnt_q == 3'd7);
    assign xfer     = shifting && sout_ready_i;

    // Ready is gated by rst_n_i so that it reads 0 while reset is held.
    // In SHIFT, a new word is taken only when the last bit leaves this
    // cycle. That is what lets words run back-to-back with no idle cycle.
    assign load_ready_o = rst_n_i && (!shifting || (xfer && last));
    assign load         = load_valid_i && load_ready_o;

    always_comb begin
        state_d    = state_q;
        mux_in_d   = mux_in_q;
        sel_d      = sel_q;
        bcnt_d     = bcnt_q;
        word_cnt_d = word_cnt_q;

        if (xfer) begin
            if (last) begin
                // The word is complete. sel and the held word keep their
                // values; a load in this same cycle overrides them below.
                word_cnt_d = word_cnt_q + 8'd1;
                state_d    = IDLE;
            end else begin
                bcnt_d = bcnt_q + 3'd1;
                sel_d  = LSB_FIRST ? (sel_q + 3'd1) : (sel_q - 3'd1);
            end
        end

        if (load) begin
            mux_in_d = din_i;
            bcnt_d   = 3'd0;
            sel_d    = SEL_FIRST;
            state_d  = SHIFT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            mux_in_q   <= 8'h00;
            sel_q      <= 3'b000;
            bcnt_q     <= 3'd0;
            word_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            mux_in_q   <= mux_in_d;
            sel_q      <= sel_d;
            bcnt_q     <= bcnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign mux_in_o     = mux_in_q;
    assign sel_o        = sel_q;
    assign sout_o       = mux_out_i;
    assign sout_valid_o = shifting;
    assign sout_last_o  = last;
    assign word_cnt_o   = word_cnt_q;
    assign state_o      = shifting;

endmodule
